// File: rtl/seg7_scan_ctrl.sv
// seg7_scan_ctrl: multiplexed seven-segment scanner with PWM dimming, guard cycle and frame pulse
module seg7_scan_ctrl #(
  parameter int N_DISP = 8,
  parameter int SCAN_DIV = 1000,
  parameter bit ACTIVE_LOW = 1'b0
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      wr_en,
  input  logic [$clog2(N_DISP)-1:0] wr_pos,
  input  logic [3:0]                wr_dig,
  input  logic                      wr_dp,
  input  logic                      wr_blank,
  input  logic                      hex_mode,
  input  logic [3:0]                bright,
  output logic [6:0]                seg,
  output logic                      dp,
  output logic [N_DISP-1:0]         an,
  output logic                      frame
);
  localparam int PW = $clog2(N_DISP);
  localparam int CW = $clog2(SCAN_DIV);
  localparam int TW = 4 + CW + 1;
  localparam logic [6:0] LUT [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                      7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
  logic [5:0] rf [N_DISP];
  logic [CW-1:0] presc;
  logic [PW-1:0] slot;
  logic [3:0] bright_l;
  logic [TW-1:0] thresh;
  logic [5:0] cur;
  logic [6:0] code;
  logic [6:0] seg_q;
  logic dp_q;
  logic [N_DISP-1:0] an_q;
  logic lit, last, wrap;
  assign thresh = ((TW'(bright_l) + TW'(1)) * TW'(SCAN_DIV)) >> 4;
  // presc=0 is the anti-ghosting guard: never lit regardless of brightness
  assign lit = presc != '0 && TW'(presc) < thresh;
  assign wrap = presc == CW'(SCAN_DIV - 1);
  assign last = wrap && slot == PW'(N_DISP - 1);
  assign cur = rf[slot];
  assign code = (!hex_mode && cur[3:0] > 4'd9) ? 7'h40 : LUT[cur[3:0]];
  always_ff @(posedge clock) begin
    if (reset) begin
      presc <= '0;
      slot <= '0;
      bright_l <= '0;
      for (int i = 0; i < N_DISP; i++) rf[i] <= 6'b10_0000;
      seg_q <= '0;
      dp_q <= 1'b0;
      an_q <= '0;
      frame <= 1'b0;
    end else begin
      presc <= wrap ? '0 : presc + CW'(1);
      if (wrap) slot <= slot == PW'(N_DISP - 1) ? '0 : slot + PW'(1);
      if (presc == '0) bright_l <= bright;
      if (wr_en && int'(wr_pos) < N_DISP) rf[wr_pos] <= {wr_blank, wr_dp, wr_dig};
      an_q <= lit ? N_DISP'(1) << slot : '0;
      seg_q <= lit && !cur[5] ? code : '0;
      dp_q <= lit && !cur[5] && cur[4];
      frame <= last;
    end
  end
  assign seg = ACTIVE_LOW ? ~seg_q : seg_q;
  assign dp = ACTIVE_LOW ? ~dp_q : dp_q;
  assign an = ACTIVE_LOW ? ~an_q : an_q;
endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// tb_seg7_scan_ctrl: vector table, directed corner sequences and model-checked random stimulus
module tb_seg7_scan_ctrl;
  localparam int N = 8, D = 16;
  typedef struct {
    logic [2:0] pos;
    logic [3:0] dig;
    logic dp, blank, hex;
    logic [6:0] seg;
    logic edp;
  } vec_t;
  logic clock = 0, reset = 1;
  logic we0 = 0, we1 = 0, we2 = 0;
  logic [3:0] wr_pos = 0, wr_dig = 0, bright = 4'd15;
  logic wr_dp = 0, wr_blank = 1, hex_mode = 0;
  logic [6:0] seg0, seg1, seg2;
  logic dp0, dp1, dp2, frame0, frame1, frame2;
  logic [7:0] an0;
  logic [3:0] an1;
  logic [5:0] an2;
  int total = 0, passed = 0;
  always #5 clock = ~clock;
  seg7_scan_ctrl #(.N_DISP(8), .SCAN_DIV(16), .ACTIVE_LOW(1'b0)) dut0 (
    .clock(clock), .reset(reset), .wr_en(we0), .wr_pos(wr_pos[2:0]), .wr_dig(wr_dig),
    .wr_dp(wr_dp), .wr_blank(wr_blank), .hex_mode(hex_mode), .bright(bright),
    .seg(seg0), .dp(dp0), .an(an0), .frame(frame0));
  seg7_scan_ctrl #(.N_DISP(4), .SCAN_DIV(16), .ACTIVE_LOW(1'b1)) dut1 (
    .clock(clock), .reset(reset), .wr_en(we1), .wr_pos(wr_pos[1:0]), .wr_dig(wr_dig),
    .wr_dp(wr_dp), .wr_blank(wr_blank), .hex_mode(hex_mode), .bright(bright),
    .seg(seg1), .dp(dp1), .an(an1), .frame(frame1));
  seg7_scan_ctrl #(.N_DISP(6), .SCAN_DIV(16), .ACTIVE_LOW(1'b0)) dut2 (
    .clock(clock), .reset(reset), .wr_en(we2), .wr_pos(wr_pos[2:0]), .wr_dig(wr_dig),
    .wr_dp(wr_dp), .wr_blank(wr_blank), .hex_mode(hex_mode), .bright(bright),
    .seg(seg2), .dp(dp2), .an(an2), .frame(frame2));
  function automatic logic [6:0] dec(input logic [3:0] d, input logic h);
    case (d)
      4'd0: return 7'h3F;
      4'd1: return 7'h06;
      4'd2: return 7'h5B;
      4'd3: return 7'h4F;
      4'd4: return 7'h66;
      4'd5: return 7'h6D;
      4'd6: return 7'h7D;
      4'd7: return 7'h07;
      4'd8: return 7'h7F;
      4'd9: return 7'h6F;
      4'd10: return h ? 7'h77 : 7'h40;
      4'd11: return h ? 7'h7C : 7'h40;
      4'd12: return h ? 7'h39 : 7'h40;
      4'd13: return h ? 7'h5E : 7'h40;
      4'd14: return h ? 7'h79 : 7'h40;
      default: return h ? 7'h71 : 7'h40;
    endcase
  endfunction
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
  endtask
  // reference: cycle n after reset shows slot n/D%N at offset n%D
  logic [5:0] mem [N];
  int n = 0, bl = 0;
  bit model_ok = 0;
  logic [6:0] e_seg;
  logic e_dp, e_frame;
  logic [7:0] e_an;
  function automatic bit lit_at(int c, int b);
    return c % D != 0 && c % D < (b + 1) * D / 16;
  endfunction
  always @(posedge clock) begin
    if (reset) begin
      n <= 0;
      bl <= 0;
      model_ok <= 1;
      for (int i = 0; i < N; i++) mem[i] <= 6'h20;
      e_seg <= 0;
      e_dp <= 0;
      e_an <= 0;
      e_frame <= 0;
    end else begin
      e_an <= lit_at(n, bl) ? 8'(1 << (n / D % N)) : 8'h00;
      e_seg <= lit_at(n, bl) && !mem[n / D % N][5] ? dec(mem[n / D % N][3:0], hex_mode) : 7'h00;
      e_dp <= lit_at(n, bl) && !mem[n / D % N][5] && mem[n / D % N][4];
      e_frame <= n % (N * D) == N * D - 1;
      if (n % D == 0) bl <= int'(bright);
      if (we0) mem[wr_pos[2:0]] <= {wr_blank, wr_dp, wr_dig};
      n <= n + 1;
    end
  end
  always @(negedge clock) if (model_ok) begin
    chk("model_seg", 32'(seg0), 32'(e_seg));
    chk("model_dp", 32'(dp0), 32'(e_dp));
    chk("model_an", 32'(an0), 32'(e_an));
    chk("model_frame", 32'(frame0), 32'(e_frame));
    chk("onehot", 32'($countones(an0) <= 1), 32'd1);
  end
  task automatic wr(input int which, input logic [3:0] pos, input logic [3:0] dig, input logic d, input logic b);
    wr_pos = pos;
    wr_dig = dig;
    wr_dp = d;
    wr_blank = b;
    we0 = which == 0;
    we1 = which == 1;
    we2 = which == 2;
    @(negedge clock);
    we0 = 0;
    we1 = 0;
    we2 = 0;
  endtask
  task automatic wait_an(input logic [7:0] t, input bit eq);
    for (int k = 0; k < 400 && ((an0 == t) != eq); k++) @(negedge clock);
    chk(eq ? "wait_an" : "wait_an_leave", 32'(an0 == t), 32'(eq));
  endtask
  task automatic wait_frame();
    for (int k = 0; k < 400 && frame0 !== 1'b1; k++) @(negedge clock);
    chk("wait_frame", 32'(frame0), 32'd1);
  endtask
  initial begin
    vec_t vecs [13];
    int s, cnt;
    vecs = '{
      '{3'd3, 4'd11, 1'b0, 1'b0, 1'b1, 7'h7C, 1'b0},
      '{3'd3, 4'd11, 1'b0, 1'b0, 1'b0, 7'h40, 1'b0},
      '{3'd3, 4'd11, 1'b1, 1'b0, 1'b1, 7'h7C, 1'b1},
      '{3'd0, 4'd0,  1'b0, 1'b0, 1'b0, 7'h3F, 1'b0},
      '{3'd1, 4'd9,  1'b0, 1'b0, 1'b0, 7'h6F, 1'b0},
      '{3'd2, 4'd10, 1'b0, 1'b0, 1'b1, 7'h77, 1'b0},
      '{3'd4, 4'd12, 1'b0, 1'b0, 1'b1, 7'h39, 1'b0},
      '{3'd5, 4'd13, 1'b0, 1'b0, 1'b1, 7'h5E, 1'b0},
      '{3'd6, 4'd14, 1'b1, 1'b0, 1'b1, 7'h79, 1'b1},
      '{3'd7, 4'd15, 1'b0, 1'b0, 1'b1, 7'h71, 1'b0},
      '{3'd7, 4'd15, 1'b0, 1'b0, 1'b0, 7'h40, 1'b0},
      '{3'd5, 4'd2,  1'b1, 1'b1, 1'b0, 7'h00, 1'b0},
      '{3'd6, 4'd7,  1'b0, 1'b0, 1'b0, 7'h07, 1'b0}};
    repeat (3) @(negedge clock);
    chk("rst_seg", 32'(seg0), 0);
    chk("rst_an", 32'(an0), 0);
    chk("rst_frame", 32'(frame0), 0);
    chk("rst_al_seg", 32'(seg1), 32'h7F);
    chk("rst_al_dp", 32'(dp1), 1);
    chk("rst_al_an", 32'(an1), 32'hF);
    chk("rst_al_frame", 32'(frame1), 0);
    reset = 0;
    for (int i = 0; i < N; i++) wr(0, 4'(i), 4'(i), 1'b0, 1'b0);
    wait_frame();
    for (int c = 0; c < N * D; c++) begin
      @(negedge clock);
      chk("scan_an", 32'(an0), c % D == 0 ? 32'd0 : 32'(1) << (c / D));
      chk("scan_seg", 32'(seg0), c % D == 0 ? 32'd0 : 32'(dec(4'(c / D), 1'b0)));
      chk("scan_frame", 32'(frame0), 32'(c == N * D - 1));
    end
    for (int v = 0; v < 13; v++) begin
      hex_mode = vecs[v].hex;
      wr(0, {1'b0, vecs[v].pos}, vecs[v].dig, vecs[v].dp, vecs[v].blank);
      wait_an(8'(1) << vecs[v].pos, 1'b0);
      wait_an(8'(1) << vecs[v].pos, 1'b1);
      chk("vec_seg", 32'(seg0), 32'(vecs[v].seg));
      chk("vec_dp", 32'(dp0), 32'(vecs[v].edp));
    end
    bright = 4'd3;
    wait_frame();
    @(negedge clock);
    chk("dim_guard", 32'(an0), 0);
    @(negedge clock);
    cnt = int'(an0 != '0);
    bright = 4'd15;
    repeat (15) begin
      @(negedge clock);
      cnt += int'(an0 != '0);
    end
    chk("dim_slot_lit", cnt, 3);
    cnt = 0;
    repeat (16) begin
      @(negedge clock);
      cnt += int'(an0 != '0);
    end
    chk("bright_next_slot_lit", cnt, 15);
    hex_mode = 0;
    for (int i = 0; i < N; i++) wr(0, 4'(i), 4'(i), 1'b0, 1'b0);
    wait_an(8'h00, 1'b1);
    @(negedge clock);
    s = 0;
    for (int i = 0; i < N; i++) if (an0[i]) s = i;
    wr(0, 4'(s), 4'd8, 1'b0, 1'b0);
    chk("wr_lat_old", 32'(seg0), 32'(dec(4'(s), 1'b0)));
    @(negedge clock);
    chk("wr_lat_new", 32'(seg0), 32'h7F);
    reset = 1;
    wr_pos = 0;
    wr_dig = 4'd5;
    wr_dp = 1;
    wr_blank = 0;
    we0 = 1;
    repeat (2) begin
      @(negedge clock);
      chk("midrst_seg", 32'(seg0), 0);
      chk("midrst_an", 32'(an0), 0);
      chk("midrst_dp", 32'(dp0), 0);
      chk("midrst_frame", 32'(frame0), 0);
    end
    reset = 0;
    we0 = 0;
    wait_an(8'h00, 1'b0);
    chk("post_rst_slot0", 32'(an0), 1);
    chk("post_rst_blank_seg", 32'(seg0), 0);
    chk("post_rst_blank_dp", 32'(dp0), 0);
    wr(1, 4'd2, 4'd8, 1'b0, 1'b0);
    for (int k = 0; k < 200 && an1 !== 4'hF; k++) @(negedge clock);
    for (int k = 0; k < 200 && an1 !== 4'b1011; k++) @(negedge clock);
    chk("al_an", 32'(an1), 32'b1011);
    chk("al_seg", 32'(seg1), 0);
    chk("al_dp", 32'(dp1), 1);
    repeat (14) @(negedge clock);
    chk("al_last_an", 32'(an1), 32'b1011);
    @(negedge clock);
    chk("al_guard_an", 32'(an1), 32'hF);
    chk("al_guard_seg", 32'(seg1), 32'h7F);
    wr(2, 4'd6, 4'd8, 1'b0, 1'b0);
    wr(2, 4'd7, 4'd8, 1'b0, 1'b0);
    cnt = 0;
    repeat (100) begin
      @(negedge clock);
      cnt += int'(seg2 != '0);
    end
    chk("oob_write_ignored", cnt, 0);
    wr(2, 4'd5, 4'd8, 1'b0, 1'b0);
    cnt = 0;
    repeat (96) begin
      @(negedge clock);
      cnt += int'(an2 == 6'b100000 && seg2 == 7'h7F);
    end
    chk("last_pos_lit", cnt, 15);
    repeat (3000) begin
      reset = $urandom_range(0, 999) == 0;
      we0 = $urandom_range(0, 2) == 0;
      wr_pos = 4'($urandom_range(0, 7));
      wr_dig = 4'($urandom);
      wr_dp = 1'($urandom);
      wr_blank = $urandom_range(0, 3) == 0;
      if ($urandom_range(0, 63) == 0) bright = 4'($urandom);
      if ($urandom_range(0, 127) == 0) hex_mode = ~hex_mode;
      @(negedge clock);
    end
    reset = 0;
    we0 = 0;
    repeat (2) @(negedge clock);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
